// File: rtl/uart_cmd_decoder_if.sv
// Register-bus request/ack and response handshake between the command decoder
// and its downstream consumers (CPU register bus, response formatter).
interface uart_cmd_decoder_if #(
    parameter int AddrWidth = 16
);
    logic                 bus_req_o;
    logic                 bus_we_o;
    logic [AddrWidth-1:0] bus_addr_o;
    logic [31:0]          bus_wdata_o;
    logic                 bus_ack_i;
    logic [31:0]          bus_rdata_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_read_o;
    logic                 rsp_err_o;
    logic [31:0]          rsp_data_o;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i,
        output rsp_valid_o, rsp_read_o, rsp_err_o, rsp_data_o,
        input  rsp_ready_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i,
        input  rsp_valid_o, rsp_read_o, rsp_err_o, rsp_data_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Streaming parser for "rFPGA,<addr>\n" / "wFPGA,<addr>,<data>\n" lines that
// issues one register-bus transaction per line and returns a status word.
module uart_cmd_decoder #(
    parameter int AddrWidth  = 16,
    parameter int AckTimeout = 1024
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                drop_o,
    uart_cmd_decoder_if.master  cmd
);

    localparam int CntWidth = $clog2(AckTimeout + 1);
    localparam logic [7:0] ChCr    = 8'h0D;
    localparam logic [7:0] ChLf    = 8'h0A;
    localparam logic [7:0] ChComma = 8'h2C;

    typedef enum logic [2:0] {
        IDLE, KEY, ADDR, DATA, DISCARD, EXEC, RESP
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           key_idx_q, key_idx_d;
    logic [35:0]          acc_q, acc_d;
    logic [3:0]           digits_q, digits_d;
    logic                 ovf_q, ovf_d;
    logic                 we_q, we_d;
    logic                 parsed_q, parsed_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_read_q, rsp_read_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 drop_q, drop_d;

    function automatic logic [7:0] key_char(input logic [2:0] idx);
        case (idx)
            3'd0:    return "F";
            3'd1:    return "P";
            3'd2:    return "G";
            3'd3:    return "A";
            default: return ChComma;
        endcase
    endfunction

    logic        is_digit;
    logic        byte_in;
    logic [35:0] acc_next;
    logic        field_ok;
    logic        addr_fits;
    logic        err_resp;

    assign byte_in   = rx_valid_i && (rx_data_i != ChCr);
    assign is_digit  = (rx_data_i >= "0") && (rx_data_i <= "9");
    // Low nibble of an ASCII digit is its value; acc < 2^32 here, so *10+9 fits 36 bits.
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + 36'(rx_data_i[3:0]);
    assign field_ok  = (digits_q != 4'd0) && !ovf_q;
    assign addr_fits = (acc_q >> AddrWidth) == 36'd0;

    // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        key_idx_d  = key_idx_q;
        acc_d      = acc_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        we_d       = we_q;
        parsed_d   = parsed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_err_d  = rsp_err_q;
        rsp_read_d = rsp_read_q;
        rsp_data_d = rsp_data_q;
        drop_d     = 1'b0;
        err_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_in && rx_data_i != ChLf) begin
                    if (rx_data_i == "r" || rx_data_i == "w") begin
                        state_d   = KEY;
                        we_d      = (rx_data_i == "w");
                        key_idx_d = 3'd0;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            KEY: begin
                if (byte_in) begin
                    if (rx_data_i == key_char(key_idx_q)) begin
                        if (key_idx_q == 3'd4) begin
                            state_d  = ADDR;
                            acc_d    = '0;
                            digits_d = '0;
                            ovf_d    = 1'b0;
                            parsed_d = 1'b1;
                        end else begin
                            key_idx_d = key_idx_q + 3'd1;
                        end
                    end else if (rx_data_i == ChLf) begin
                        err_resp = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            ADDR, DATA: begin
                if (byte_in) begin
                    if (is_digit) begin
                        acc_d    = acc_next;
                        digits_d = (digits_q == 4'hF) ? digits_q : digits_q + 4'd1;
                        ovf_d    = ovf_q || (acc_next[35:32] != 4'd0) || (digits_q >= 4'd10);
                    end else if (state_q == ADDR && rx_data_i == ChComma && we_q
                                 && field_ok && addr_fits) begin
                        addr_d   = acc_q[AddrWidth-1:0];
                        acc_d    = '0;
                        digits_d = '0;
                        state_d  = DATA;
                    end else if (state_q == ADDR && rx_data_i == ChLf && !we_q
                                 && field_ok && addr_fits) begin
                        addr_d  = acc_q[AddrWidth-1:0];
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else if (state_q == DATA && rx_data_i == ChLf && field_ok) begin
                        wdata_d = acc_q[31:0];
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else if (rx_data_i == ChLf) begin
                        err_resp = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (rx_valid_i && rx_data_i == ChLf) begin
                    err_resp = 1'b1;
                end
            end
            EXEC: begin
                drop_d = rx_valid_i;
                cnt_d  = cnt_q + CntWidth'(1);
                // An ack on the timeout edge still completes the transaction.
                if (cmd.bus_ack_i) begin
                    rsp_err_d  = 1'b0;
                    rsp_read_d = !we_q;
                    rsp_data_d = we_q ? 32'd0 : cmd.bus_rdata_i;
                    state_d    = RESP;
                end else if (cnt_q == CntWidth'(AckTimeout - 1)) begin
                    err_resp = 1'b1;
                end
            end
            RESP: begin
                drop_d = rx_valid_i;
                if (cmd.rsp_ready_i) begin
                    state_d  = IDLE;
                    parsed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Lines rejected before the address field never report as reads.
        if (err_resp) begin
            rsp_err_d  = 1'b1;
            rsp_read_d = parsed_q && !we_q;
            rsp_data_d = 32'd0;
            state_d    = RESP;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            key_idx_q  <= '0;
            acc_q      <= '0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            parsed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_err_q  <= 1'b0;
            rsp_read_q <= 1'b0;
            rsp_data_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_idx_q  <= key_idx_d;
            acc_q      <= acc_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            we_q       <= we_d;
            parsed_q   <= parsed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_err_q  <= rsp_err_d;
            rsp_read_q <= rsp_read_d;
            rsp_data_q <= rsp_data_d;
            drop_q     <= drop_d;
        end
    end

    assign cmd.bus_req_o   = (state_q == EXEC);
    assign cmd.bus_we_o    = we_q;
    assign cmd.bus_addr_o  = addr_q;
    assign cmd.bus_wdata_o = wdata_q;
    assign cmd.rsp_valid_o = (state_q == RESP);
    assign cmd.rsp_read_o  = rsp_read_q;
    assign cmd.rsp_err_o   = rsp_err_q;
    assign cmd.rsp_data_o  = rsp_data_q;
    assign drop_o          = drop_q;

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Hardware ASCII command decoder that sits directly downstream of the `uart` receiver (`data_o`/`data_valid_o`). It assembles received bytes into `rFPGA,<addr>\n` and `wFPGA,<addr>,<data>\n` lines and issues the matching single-word transaction on the CPU-side register bus. It then returns a status/read-data word for the upstream response formatter. Decimal fields are parsed on the fly, one byte at a time; no line buffer is kept.

## Interface
- `AddrWidth`, 16: bus address width; must equal `address_width`.
- `AckTimeout`, 1024: cycles `bus_req_o` may stay high without `bus_ack_i` before the transaction is abandoned.
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  reset; one clock, reset asynchronous and active-high.
- `rx_data_i`  in  8  received byte.
- `rx_valid_i`  in  1  one-cycle strobe, one per byte.
- `bus_req_o`  out  1  transaction request; held until ack or timeout.
- `bus_we_o`  out  1  1 = write, 0 = read; stable while `bus_req_o` is high.
- `bus_addr_o`  out  AddrWidth  transaction address.
- `bus_wdata_o`  out  32  write data.
- `bus_ack_i`  in  1  one-cycle completion strobe.
- `bus_rdata_i`  in  32  read data, valid with `bus_ack_i`.
- `rsp_valid_o`  out  1  response available; held until accepted.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_read_o`  out  1  response belongs to a read.
- `rsp_err_o`  out  1  line rejected or bus timeout.
- `rsp_data_o`  out  32  read data; 0 for writes and errors.
- `drop_o`  out  1  one-cycle pulse when a byte arrives in EXEC or RESP and is discarded.

## Operation
- States: IDLE, KEY, ADDR, DATA, DISCARD, EXEC, RESP.
- Byte handling outside EXEC and RESP:
  - `\r` (0x0D) is ignored in every state.
  - `\n` in IDLE is ignored, so empty lines produce no response.
- IDLE:
  - `r` or `w` goes to KEY and latches `bus_we_o` (`w` = 1).
  - Any other byte goes to DISCARD.
- KEY: the following bytes must be exactly `FPGA,`.
  - After the comma, go to ADDR with the accumulator and digit count cleared.
  - A mismatch goes to DISCARD.
- ADDR and DATA: digits `0`-`9` update `acc = acc*10 + digit`, tracked at 36-bit width.
  - If the result reaches 2^32 or more, set the overflow flag.
  - Digit count above 10 also sets the overflow flag.
- ADDR terminators:
  - `,` on a write with at least one digit: latch the address, go to DATA.
  - `\n` on a read with at least one digit: latch the address, go to EXEC.
- DATA terminator: `\n` with at least one digit latches `bus_wdata_o` and goes to EXEC.
- Errors: any of the following go to DISCARD, or straight to RESP with `rsp_err_o` = 1 if the byte is `\n`:
  - an overflow;
  - an address value of 2^AddrWidth or more;
  - an empty field;
  - a wrong terminator;
  - a non-digit byte.
- DISCARD: wait for `\n`, then go to RESP with error.
- EXEC:
  - Hold `bus_req_o`.
  - On `bus_ack_i`, capture `bus_rdata_i` if it is a read, then go to RESP.
  - If the timeout counter reaches `AckTimeout`, go to RESP with error.
- RESP:
  - Hold `rsp_*` stable until `rsp_valid_o && rsp_ready_i`, then go to IDLE.
  - `rsp_read_o` = `!bus_we_o` for parsed lines and 0 for lines rejected in IDLE or KEY.

## Timing
- Reset values: all outputs 0, state IDLE, accumulator, flags and timeout counter 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-line or mid-transaction drops everything; no response is issued after reset.
- `\n` sampled at edge N puts the block in EXEC, with `bus_req_o` high after edge N.
- `bus_ack_i` sampled at edge M drops `bus_req_o` and raises `rsp_valid_o` after edge M. Data arrives on the same cycle, so there is no bubble.
- `bus_ack_i` while `bus_req_o` is low is ignored.
- An ack arriving on the same edge the timeout counter reaches `AckTimeout` wins; no error is flagged.
- Timeout: `bus_req_o` falls after exactly `AckTimeout` cycles high.
- `rsp_ready_i` already high when `rsp_valid_o` rises completes the response in one cycle. IDLE then accepts a byte on the next edge.
- Every parse state accepts one byte per cycle, with no backpressure toward the UART.

## Test plan
- `wFPGA,36868,3735928559\n`, ack after 3 cycles:
  - `bus_req_o` high for 4 cycles with `bus_we_o`=1, `bus_addr_o`=0x9004, `bus_wdata_o`=0xDEADBEEF.
  - Response: `rsp_err_o`=0, `rsp_read_o`=0, `rsp_data_o`=0.
- `rFPGA,36864\n`, ack with `bus_rdata_i`=0x12345678:
  - `bus_we_o`=0, `bus_addr_o`=0x9000.
  - Response: `rsp_data_o`=0x12345678, `rsp_read_o`=1.
- `wFPGA,1,4294967296\n`: no `bus_req_o`; `rsp_err_o`=1. Also `rFPGA,65536\n` with AddrWidth=16: same result.
- `\n` then `readFPGAVersion\r\n`: no response for the blank line, one error response, no bus activity.
- `rFPGA,4\n` with no ack and AckTimeout=8: `bus_req_o` high exactly 8 cycles, then `rsp_err_o`=1.
- Reset behaviour:
  - `reset_i` pulsed after `wFPGA,12`: no bus request or response follows; a subsequent `rFPGA,8\n` executes normally.
  - A byte sent during RESP produces one `drop_o` pulse.
